// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter between an ALU and a load unit, with a pending-write
// scoreboard for hazard queries and a sticky protocol-error flag.
module regfile_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rsv_valid,
    input  logic [ADDR_WIDTH-1:0] rsv_addr,
    input  logic [ADDR_WIDTH-1:0] chk_addr1,
    input  logic [ADDR_WIDTH-1:0] chk_addr2,
    output logic                  chk_busy1,
    output logic                  chk_busy2,
    input  logic                  exu_valid,
    input  logic [ADDR_WIDTH-1:0] exu_addr,
    input  logic [DATA_WIDTH-1:0] exu_data,
    output logic                  exu_ready,
    input  logic                  lsu_valid,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  lsu_ready,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  sb_err
);

    localparam int NREG = 1 << ADDR_WIDTH;

    logic                  last_lsu_r;
    logic [NREG-1:0]       busy_r;
    logic [NREG-1:0]       busy_nxt_s;
    logic                  any_xfer_s;
    logic [ADDR_WIDTH-1:0] win_addr_s;
    logic [DATA_WIDTH-1:0] win_data_s;
    logic                  rsv_busy_s;
    logic                  wr_idle_s;

    // last_lsu_r=1 means the LSU won the previous grant, so a tie goes to the EXU.
    assign exu_ready  = exu_valid & (~lsu_valid | last_lsu_r);
    assign lsu_ready  = lsu_valid & (~exu_valid | ~last_lsu_r);
    assign any_xfer_s = exu_ready | lsu_ready;

    assign chk_busy1 = busy_r[chk_addr1];
    assign chk_busy2 = busy_r[chk_addr2];

    // Select the granted source's address and data.
    always_comb begin
        win_addr_s = exu_addr;
        win_data_s = exu_data;
        if (lsu_ready) begin
            win_addr_s = lsu_addr;
            win_data_s = lsu_data;
        end else begin
            win_addr_s = exu_addr;
            win_data_s = exu_data;
        end
    end

    // Scoreboard next state: a reservation beats a retiring write to the same register.
    always_comb begin
        busy_nxt_s = busy_r;
        for (int i = 1; i < NREG; i++) begin
            if (rsv_valid && (rsv_addr == ADDR_WIDTH'(i))) begin
                busy_nxt_s[i] = 1'b1;
            end else if (rf_wen && (rf_waddr == ADDR_WIDTH'(i))) begin
                busy_nxt_s[i] = 1'b0;
            end else begin
                busy_nxt_s[i] = busy_r[i];
            end
        end
        busy_nxt_s[0] = 1'b0;
    end

    assign rsv_busy_s = rsv_valid && (rsv_addr != '0) && busy_r[rsv_addr]
                        && !(rf_wen && (rf_waddr == rsv_addr));
    assign wr_idle_s  = rf_wen && !busy_r[rf_waddr];

    // Grant history and registered write port; address 0 is accepted but never written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_lsu_r <= 1'b1;
            rf_wen     <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
        end else if (any_xfer_s) begin
            last_lsu_r <= lsu_ready;
            rf_wen     <= (win_addr_s != '0);
            rf_waddr   <= win_addr_s;
            rf_wdata   <= win_data_s;
        end else begin
            last_lsu_r <= last_lsu_r;
            rf_wen     <= 1'b0;
            rf_waddr   <= rf_waddr;
            rf_wdata   <= rf_wdata;
        end
    end

    // Busy bits and the sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r <= '0;
            sb_err <= 1'b0;
        end else begin
            busy_r <= busy_nxt_s;
            sb_err <= sb_err | rsv_busy_s | wr_idle_s;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a per-cycle vector table plus
// hand-written round-robin and reset-discard sequences.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rsv_valid = 1'b0;
    logic [4:0]  rsv_addr = 5'd0;
    logic [4:0]  chk_addr1 = 5'd0;
    logic [4:0]  chk_addr2 = 5'd0;
    logic        chk_busy1, chk_busy2;
    logic        exu_valid = 1'b0;
    logic [4:0]  exu_addr = 5'd0;
    logic [31:0] exu_data = 32'd0;
    logic        exu_ready;
    logic        lsu_valid = 1'b0;
    logic [4:0]  lsu_addr = 5'd0;
    logic [31:0] lsu_data = 32'd0;
    logic        lsu_ready;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        sb_err;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
        .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
        .exu_valid(exu_valid), .exu_addr(exu_addr), .exu_data(exu_data), .exu_ready(exu_ready),
        .lsu_valid(lsu_valid), .lsu_addr(lsu_addr), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rstb;
        logic        rv;
        logic [4:0]  ra;
        logic        ev;
        logic [4:0]  ea;
        logic [31:0] ed;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic [4:0]  c1;
        logic [4:0]  c2;
        logic        xer;
        logic        xlr;
        logic        xb1;
        logic        xb2;
        logic        xwen;
        logic [4:0]  xwa;
        logic [31:0] xwd;
        logic        xerr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rstb, logic rv, logic [4:0] ra,
                                logic ev, logic [4:0] ea, logic [31:0] ed,
                                logic lv, logic [4:0] la, logic [31:0] ld,
                                logic [4:0] c1, logic [4:0] c2,
                                logic xer, logic xlr, logic xb1, logic xb2,
                                logic xwen, logic [4:0] xwa, logic [31:0] xwd, logic xerr);
        mk = '{rstb, rv, ra, ev, ea, ed, lv, la, ld, c1, c2,
               xer, xlr, xb1, xb2, xwen, xwa, xwd, xerr};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        #1;
        rst = 1'b1;
    endtask

    task automatic idle_inputs();
        rsv_valid = 1'b0;
        exu_valid = 1'b0;
        lsu_valid = 1'b0;
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        if (v.rstb) begin
            idle_inputs();
            pulse_reset();
        end
        rsv_valid = v.rv; rsv_addr = v.ra;
        exu_valid = v.ev; exu_addr = v.ea; exu_data = v.ed;
        lsu_valid = v.lv; lsu_addr = v.la; lsu_data = v.ld;
        chk_addr1 = v.c1; chk_addr2 = v.c2;
        #1;
        chk($sformatf("row%0d_exu_ready", idx), 32'(exu_ready), 32'(v.xer));
        chk($sformatf("row%0d_lsu_ready", idx), 32'(lsu_ready), 32'(v.xlr));
        chk($sformatf("row%0d_chk_busy1", idx), 32'(chk_busy1), 32'(v.xb1));
        chk($sformatf("row%0d_chk_busy2", idx), 32'(chk_busy2), 32'(v.xb2));
        chk($sformatf("row%0d_rf_wen", idx), 32'(rf_wen), 32'(v.xwen));
        chk($sformatf("row%0d_sb_err", idx), 32'(sb_err), 32'(v.xerr));
        if (v.xwen) begin
            chk($sformatf("row%0d_rf_waddr", idx), 32'(rf_waddr), 32'(v.xwa));
            chk($sformatf("row%0d_rf_wdata", idx), rf_wdata, v.xwd);
        end
    endtask

    initial begin
        int ne;
        int nl;
        logic        pw;
        logic [4:0]  pa;
        logic [31:0] pd;

        // Single reserve/write/retire of x5.
        tbl.push_back(mk(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0));
        // First tie after reset goes to the EXU, then the LSU.
        tbl.push_back(mk(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd3, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,  1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 5'd4, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd3, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,  1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 5'd0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 5'd3, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,  1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,  1'b1, 5'd4, 32'h22, 5'd3, 5'd4, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 32'h11, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd3, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd4, 32'h22, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd3, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,  1'b0));
        // Reserve and retire of x7 on one edge, then an unreserved write to x9.
        tbl.push_back(mk(1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,  1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 5'd0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'h0,  5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,  1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd7, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 32'h77, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd7, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,  1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,  1'b1, 5'd9, 32'h99, 5'd9, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,  1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd7, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd9, 32'h99, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd7, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,  1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd7, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,  1'b1));
        // Write to x0 is accepted but never reaches the register file.
        tbl.push_back(mk(1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0));

        // Outputs while held in reset.
        #2;
        chk("reset_rf_wen", 32'(rf_wen), 32'd0);
        chk("reset_rf_waddr", 32'(rf_waddr), 32'd0);
        chk("reset_rf_wdata", rf_wdata, 32'd0);
        chk("reset_sb_err", 32'(sb_err), 32'd0);
        chk("reset_chk_busy1", 32'(chk_busy1), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // Six cycles of both sources valid: grants alternate starting with the EXU.
        @(negedge clk);
        idle_inputs();
        pulse_reset();
        for (int n = 0; n < 6; n++) begin
            rsv_valid = 1'b1;
            rsv_addr  = (n < 3) ? 5'(10 + n) : 5'(20 + n - 3);
            @(negedge clk);
        end
        rsv_valid = 1'b0;
        ne = 0;
        nl = 0;
        pw = 1'b0;
        pa = 5'd0;
        pd = 32'd0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            if (k < 6) begin
                exu_valid = 1'b1; exu_addr = 5'(10 + ne); exu_data = 32'hE0 + 32'(ne);
                lsu_valid = 1'b1; lsu_addr = 5'(20 + nl); lsu_data = 32'hA0 + 32'(nl);
            end else begin
                exu_valid = 1'b0;
                lsu_valid = 1'b0;
            end
            #1;
            if (k < 6) begin
                chk($sformatf("rr%0d_exu_ready", k), 32'(exu_ready), 32'((k % 2) == 0));
                chk($sformatf("rr%0d_lsu_ready", k), 32'(lsu_ready), 32'((k % 2) == 1));
            end
            chk($sformatf("rr%0d_rf_wen", k), 32'(rf_wen), 32'(pw));
            if (pw) begin
                chk($sformatf("rr%0d_rf_waddr", k), 32'(rf_waddr), 32'(pa));
                chk($sformatf("rr%0d_rf_wdata", k), rf_wdata, pd);
            end
            if (k < 6) begin
                if ((k % 2) == 0) begin
                    pa = exu_addr; pd = exu_data; ne++;
                end else begin
                    pa = lsu_addr; pd = lsu_data; nl++;
                end
                pw = 1'b1;
            end else begin
                pw = 1'b0;
            end
        end
        chk("rr_sb_err", 32'(sb_err), 32'd0);

        // A write pending in the output stage is dropped by reset; transfers during reset are ignored.
        @(negedge clk);
        pulse_reset();
        rsv_valid = 1'b1; rsv_addr = 5'd6; chk_addr1 = 5'd6;
        @(negedge clk);
        rsv_valid = 1'b0;
        exu_valid = 1'b1; exu_addr = 5'd6; exu_data = 32'h66;
        #1;
        chk("rstdrop_exu_ready", 32'(exu_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rstdrop_rf_wen", 32'(rf_wen), 32'd0);
        chk("rstdrop_busy6", 32'(chk_busy1), 32'd0);
        chk("rstdrop_sb_err", 32'(sb_err), 32'd0);
        chk("rstdrop_ready_in_reset", 32'(exu_ready), 32'd1);
        @(negedge clk);
        exu_valid = 1'b0;
        #1;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("rstafter%0d_rf_wen", k), 32'(rf_wen), 32'd0);
            chk($sformatf("rstafter%0d_busy6", k), 32'(chk_busy1), 32'd0);
            chk($sformatf("rstafter%0d_sb_err", k), 32'(sb_err), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
